// File: rtl/inv_factorial_seq.sv
// Sequential inverse factorial: finds the largest n with n! <= value, one multiply per cycle.
// Reports whether value is exactly n!, and whether the search stopped at the accumulator width.
module inv_factorial_seq #(
    parameter int WIDTH = 32,
    parameter int NW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [NW-1:0]    n_out,
    output logic             exact,
    output logic             sat
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [NW-1:0]    k_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [NW-1:0]    n_out_reg;
    logic             exact_reg;
    logic             sat_reg;

    logic [NW-1:0]      k_next;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   prod_hi;
    logic [WIDTH-1:0]   prod_lo;

    assign k_next    = k_reg + {{(NW-1){1'b0}}, 1'b1};
    assign prod_next = {{WIDTH{1'b0}}, acc_reg} * {{(2*WIDTH-NW){1'b0}}, k_next};
    assign prod_hi   = prod_next[2*WIDTH-1:WIDTH];
    assign prod_lo   = prod_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            target_reg <= '0;
            acc_reg    <= '0;
            k_reg      <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            n_out_reg  <= '0;
            exact_reg  <= 1'b0;
            sat_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        target_reg <= value;
                        acc_reg    <= {{(WIDTH-1){1'b0}}, 1'b1};
                        k_reg      <= {{(NW-1){1'b0}}, 1'b1};
                        exact_reg  <= 1'b0;
                        sat_reg    <= 1'b0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    if (acc_reg == target_reg) begin
                        n_out_reg <= k_reg;
                        exact_reg <= 1'b1;
                        sat_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (acc_reg > target_reg) begin
                        // Only reachable for value 0, since acc starts at 1! = 1.
                        n_out_reg <= k_reg - {{(NW-1){1'b0}}, 1'b1};
                        exact_reg <= 1'b0;
                        sat_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (prod_hi != '0) begin
                        n_out_reg <= k_reg;
                        exact_reg <= 1'b0;
                        sat_reg   <= 1'b1;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (prod_lo > target_reg) begin
                        // Stopping on the overshooting product keeps latency equal to n for
                        // inexact values, matching the exact case.
                        n_out_reg <= k_reg;
                        exact_reg <= 1'b0;
                        sat_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        acc_reg <= prod_lo;
                        k_reg   <= k_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign n_out = n_out_reg;
    assign exact = exact_reg;
    assign sat   = sat_reg;

endmodule

// File: tb/tb_inv_factorial_seq.sv
// Testbench for inv_factorial_seq: scoreboard of expected results checked on every done pulse.
// Scenario tasks add handshake, timing and reset checks of their own.
module tb_inv_factorial_seq;

    localparam int WIDTH = 32;
    localparam int NW    = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [NW-1:0]    n_out;
    logic             exact;
    logic             sat;

    inv_factorial_seq #(.WIDTH(WIDTH), .NW(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .n_out (n_out),
        .exact (exact),
        .sat   (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] v;
        logic [NW-1:0]    n;
        logic             exact;
        logic             sat;
        int               lat;
        int               e0;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: walk factorials in 64-bit arithmetic until the next one exceeds value or 2^32.
    function automatic exp_t model(input logic [WIDTH-1:0] v, input int e0);
        exp_t            e;
        longint unsigned f;
        int              n;
        e.v  = v;
        e.e0 = e0;
        if (v == '0) begin
            e.n = '0; e.exact = 1'b0; e.sat = 1'b0; e.lat = 1;
        end else begin
            f = 1;
            n = 1;
            while ((f * 64'(n + 1)) <= 64'(v) && (f * 64'(n + 1)) < 64'h1_0000_0000) begin
                f = f * 64'(n + 1);
                n++;
            end
            e.n     = n[NW-1:0];
            e.exact = (f == 64'(v));
            e.sat   = !e.exact && ((f * 64'(n + 1)) >= 64'h1_0000_0000);
            e.lat   = n;
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: done=1 with n_out=%0d, required no pending operation", n_out);
            end else begin
                e = sb.pop_front();
                vectors++;
                if (n_out !== e.n) begin
                    miscompares++;
                    $display("FAIL n_out value=%0d: got %0d required %0d", e.v, n_out, e.n);
                end
                vectors++;
                if (exact !== e.exact) begin
                    miscompares++;
                    $display("FAIL exact value=%0d: got %0b required %0b", e.v, exact, e.exact);
                end
                vectors++;
                if (sat !== e.sat) begin
                    miscompares++;
                    $display("FAIL sat value=%0d: got %0b required %0b", e.v, sat, e.sat);
                end
                vectors++;
                if ((cyc - e.e0) !== e.lat) begin
                    miscompares++;
                    $display("FAIL latency value=%0d: got %0d required %0d", e.v, cyc - e.e0, e.lat);
                end
                $display("value=%0d n_out=%0d exact=%0b sat=%0b latency=%0d", e.v, n_out, exact, sat, cyc - e.e0);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] v);
        start = 1'b1;
        value = v;
        sb.push_back(model(v, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        value = $urandom;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (!done && i < 60) begin
            @(negedge clk);
            i++;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s_timeout: done=0, required 1 within 60 cycles", tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b required 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b required 0", done); end
        vectors++;
        if (n_out !== '0) begin miscompares++; $display("FAIL reset_n_out: got %0d required 0", n_out); end
        vectors++;
        if (exact !== 1'b0) begin miscompares++; $display("FAIL reset_exact: got %0b required 0", exact); end
        vectors++;
        if (sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %0b required 0", sat); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exact_120();
        int bc;
        int i;
        issue(32'd120);
        bc = 0;
        i  = 0;
        while (!done && i < 60) begin
            if (busy) bc++;
            @(negedge clk);
            i++;
        end
        vectors++;
        if (bc !== 5) begin miscompares++; $display("FAIL busy_cycles_120: got %0d required 5", bc); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_at_done: got %0b required 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_small();
        issue(32'd100); wait_done("v100");
        issue(32'd0);   wait_done("v0");
        issue(32'd1);   wait_done("v1");
        @(negedge clk);
    endtask

    task automatic test_saturation();
        issue(32'd479001600);  wait_done("v12fact");
        issue(32'hFFFF_FFFF); wait_done("vmax");
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int pulses;
        issue(32'd3628800);
        repeat (2) @(negedge clk);
        start = 1'b1;
        value = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("v10fact");
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL extra_done_pulses: got %0d required 0", pulses); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        value = 32'd720;
        sb.push_back(model(32'd720, cyc + 1));
        @(negedge clk);
        value = 32'd40320;
        wait_done("b2b_first");
        sb.push_back(model(32'd40320, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_no_gap: got %0b required 1", busy); end
        wait_done("b2b_second");
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int pulses;
        start = 1'b1;
        value = 32'd5040;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %0b required 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %0b required 0", done); end
        vectors++;
        if (n_out !== '0) begin miscompares++; $display("FAIL abort_n_out: got %0d required 0", n_out); end
        vectors++;
        if (exact !== 1'b0) begin miscompares++; $display("FAIL abort_exact: got %0b required 0", exact); end
        vectors++;
        if (sat !== 1'b0) begin miscompares++; $display("FAIL abort_sat: got %0b required 0", sat); end
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL abort_done_pulses: got %0d required 0", pulses); end
        issue(32'd24);
        wait_done("after_abort");
        @(negedge clk);
    endtask

    task automatic test_random();
        repeat (10) begin
            issue($urandom >> $urandom_range(0, 31));
            wait_done("random");
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_exact_120();
        test_small();
        test_saturation();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
